cascaded_down_timer: RTL



---
 rtl/cascaded_down_timer_pkg.sv | 13 +
 rtl/n_bit_down_counter.sv | 29 ++
 rtl/cascaded_down_timer.sv | 109 ++++++++++
 3 files changed

// File: rtl/cascaded_down_timer_pkg.sv
// rtl/cascaded_down_timer_pkg.sv - shared state encoding and width helper for the cascaded down timer
package cascaded_down_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int total_width(input int counter_size, input int num_counters);
    return counter_size * num_counters;
  endfunction

endpackage

// File: rtl/n_bit_down_counter.sv
// rtl/n_bit_down_counter.sv - one loadable down-counter stage with zero flag for the borrow chain
module n_bit_down_counter #(
  parameter int COUNTER_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    load,
  input  logic [COUNTER_SIZE-1:0] loadValue,
  output logic [COUNTER_SIZE-1:0] count,
  output logic                    isZero
);

  localparam logic [COUNTER_SIZE-1:0] ONE = COUNTER_SIZE'(1);

  // Decrementing from zero wraps to all-ones, which is what the borrow chain relies on.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (enable) begin
      count <= count - ONE;
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/cascaded_down_timer.sv
// rtl/cascaded_down_timer.sv - chained down-counter timer with expiry pulse and optional auto-reload
module cascaded_down_timer
  import cascaded_down_timer_pkg::*;
#(
  parameter int  COUNTER_SIZE = 16,
  parameter int  NUM_COUNTERS = 4,
  localparam int W            = total_width(COUNTER_SIZE, NUM_COUNTERS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadValue,
  input  logic         start,
  input  logic         stop,
  input  logic         autoReload,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         expired
);

  localparam logic [COUNTER_SIZE-1:0] STAGE_ONE = COUNTER_SIZE'(1);
  localparam logic [NUM_COUNTERS-1:0] LSB_MASK  = NUM_COUNTERS'(1);

  state_t                  state;
  state_t                  state_next;
  logic                    expired_next;
  logic [W-1:0]            reload_reg;
  logic [NUM_COUNTERS-1:0] is_zero;
  logic [NUM_COUNTERS-1:0] borrow;
  logic [NUM_COUNTERS-1:0] stage_en;
  logic                    stage_load;
  logic [W-1:0]            stage_value;
  logic                    count_dec;
  logic                    count_is_one;
  logic                    count_is_zero;

  assign count_is_zero = &is_zero;
  assign count_is_one  = (count[COUNTER_SIZE-1:0] == STAGE_ONE) && (&(is_zero | LSB_MASK));

  // borrow[j] is high when every stage below j is zero; stage 0 always borrows.
  always_comb begin
    borrow    = '0;
    borrow[0] = 1'b1;
    for (int j = 1; j < NUM_COUNTERS; j++) begin
      borrow[j] = borrow[j-1] & is_zero[j-1];
    end
  end

  assign stage_en = {NUM_COUNTERS{count_dec}} & borrow;

  always_comb begin
    state_next   = state;
    expired_next = 1'b0;
    stage_load   = 1'b0;
    stage_value  = loadValue;
    count_dec    = 1'b0;
    if (load) begin
      stage_load = 1'b1;
      state_next = IDLE;
    end else if (state == RUN) begin
      if (stop) begin
        state_next = IDLE;
      end else if (count_is_one && autoReload) begin
        stage_load   = 1'b1;
        stage_value  = reload_reg;
        expired_next = 1'b1;
      end else begin
        count_dec = 1'b1;
        if (count_is_one) begin
          state_next   = IDLE;
          expired_next = 1'b1;
        end
      end
    end else if (start && !stop && !count_is_zero) begin
      state_next = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      expired    <= 1'b0;
      reload_reg <= '0;
    end else begin
      state   <= state_next;
      expired <= expired_next;
      if (load) begin
        reload_reg <= loadValue;
      end
    end
  end

  assign busy = (state == RUN);

  for (genvar j = 0; j < NUM_COUNTERS; j++) begin : g_stage
    n_bit_down_counter #(
      .COUNTER_SIZE(COUNTER_SIZE)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .enable   (stage_en[j]),
      .load     (stage_load),
      .loadValue(stage_value[j*COUNTER_SIZE +: COUNTER_SIZE]),
      .count    (count[j*COUNTER_SIZE +: COUNTER_SIZE]),
      .isZero   (is_zero[j])
    );
  end

endmodule
